// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB arbiter.
// State encoding, arbitration modes and requester index.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  typedef logic mst_idx_t;

  localparam mst_idx_t M0 = 1'b0;
  localparam mst_idx_t M1 = 1'b1;

  function automatic logic [1:0] idx2oh(input mst_idx_t i);
    return (i == M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB-style bundle used on both the requester and slave sides.
// master drives the request, slave returns the response.
interface apb_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pdata;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [DW/8-1:0] pstb;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            perr;

  modport master (
    output paddr, pdata, psel, penable, pwrite, pstb,
    input  prdata, pready, perr
  );

  modport slave (
    input  paddr, pdata, psel, penable, pwrite, pstb,
    output prdata, pready, perr
  );

endinterface

// File: rtl/apb_master_arbiter_pick.sv
// Two-way picker: lone requester wins outright, a tie goes
// to the non-last owner (round-robin) or to m0 (fixed).
module apb_arb_pick
  import apb_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  mst_idx_t   last_i,
  input  logic       mode_i,
  output logic [1:0] win_o
);

  // one-hot winner, zero when nobody asks
  always_comb begin
    win_o = 2'b00;
    unique case (req_i)
      2'b01:   win_o = 2'b01;
      2'b10:   win_o = 2'b10;
      2'b11: begin
        if (mode_i == ARB_RR)
          win_o = idx2oh(~last_i);
        else
          win_o = 2'b01;
      end
      default: win_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between two requesters, one whole
// transfer at a time, with freshly generated setup/access phases.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 1
) (
  input  logic       AXI_PCLK,
  input  logic       AXI_PRESETn,
  apb_arb_if.slave   m0,
  apb_arb_if.slave   m1,
  apb_arb_if.master  apb,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int SW = DATA_WIDTH / 8;
  localparam logic MODE = (ARB_MODE != 0) ? ARB_RR : ARB_FIXED;

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  mst_idx_t   last_q, last_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic [SW-1:0]         stb_q, stb_d;

  logic [1:0] win;
  logic       done;
  logic       unused_penable;

  // requester phase inputs carry no meaning here
  assign unused_penable = &{1'b0, m0.penable, m1.penable};

  apb_arb_pick u_pick (
    .req_i  ({m1.psel, m0.psel}),
    .last_i (last_q),
    .mode_i (MODE),
    .win_o  (win)
  );

  // state, owner and captured request registers
  always_ff @(posedge AXI_PCLK or negedge AXI_PRESETn) begin
    if (!AXI_PRESETn) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= M1;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      stb_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      stb_q   <= stb_d;
    end
  end

  // next state; capture only in IDLE so later input churn is ignored
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    stb_d   = stb_q;
    unique case (state_q)
      IDLE: begin
        if (|win) begin
          state_d = SETUP;
          grant_d = win;
          addr_d  = win[1] ? m1.paddr  : m0.paddr;
          data_d  = win[1] ? m1.pdata  : m0.pdata;
          wr_d    = win[1] ? m1.pwrite : m0.pwrite;
          stb_d   = win[1] ? m1.pstb   : m0.pstb;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (apb.pready) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = grant_q[1] ? M1 : M0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done = (state_q == ACCESS) && apb.pready;

  assign apb.psel    = (state_q != IDLE);
  assign apb.penable = (state_q == ACCESS);
  assign apb.paddr   = addr_q;
  assign apb.pdata   = data_q;
  assign apb.pwrite  = wr_q;
  assign apb.pstb    = stb_q;

  assign m0.pready = done & grant_q[0];
  assign m1.pready = done & grant_q[1];
  assign m0.perr   = m0.pready & apb.perr;
  assign m1.perr   = m1.pready & apb.perr;
  assign m0.prdata = apb.prdata;
  assign m1.prdata = apb.prdata;

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus a
// randomized run against a transfer-level reference model.
module tb_apb_master_arbiter;

  logic clk;
  logic rst_n;
  logic use_fx;

  logic [31:0] q_addr [2];
  logic [31:0] q_data [2];
  logic        q_wr   [2];
  logic [3:0]  q_stb  [2];
  logic        q_sel  [2];

  logic        s_rdy;
  logic        s_err;
  logic [31:0] s_rdata;

  int n_chk;
  int n_fail;

  apb_arb_if #(.AW(32), .DW(32)) m0r ();
  apb_arb_if #(.AW(32), .DW(32)) m1r ();
  apb_arb_if #(.AW(32), .DW(32)) sr ();
  apb_arb_if #(.AW(32), .DW(32)) m0f ();
  apb_arb_if #(.AW(32), .DW(32)) m1f ();
  apb_arb_if #(.AW(32), .DW(32)) sf ();

  logic [1:0] g_r, g_f;
  logic       b_r, b_f;

  apb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1)) dut_rr (
    .AXI_PCLK    (clk),
    .AXI_PRESETn (rst_n),
    .m0          (m0r),
    .m1          (m1r),
    .apb         (sr),
    .grant       (g_r),
    .busy        (b_r)
  );

  apb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0)) dut_fx (
    .AXI_PCLK    (clk),
    .AXI_PRESETn (rst_n),
    .m0          (m0f),
    .m1          (m1f),
    .apb         (sf),
    .grant       (g_f),
    .busy        (b_f)
  );

  // requester and slave stimulus; only the selected DUT sees traffic
  assign m0r.paddr = q_addr[0];
  assign m0r.pdata = q_data[0];
  assign m0r.pwrite = q_wr[0];
  assign m0r.pstb = q_stb[0];
  assign m0r.psel = q_sel[0] & ~use_fx;
  assign m0r.penable = q_sel[0];
  assign m1r.paddr = q_addr[1];
  assign m1r.pdata = q_data[1];
  assign m1r.pwrite = q_wr[1];
  assign m1r.pstb = q_stb[1];
  assign m1r.psel = q_sel[1] & ~use_fx;
  assign m1r.penable = q_sel[1];
  assign m0f.paddr = q_addr[0];
  assign m0f.pdata = q_data[0];
  assign m0f.pwrite = q_wr[0];
  assign m0f.pstb = q_stb[0];
  assign m0f.psel = q_sel[0] & use_fx;
  assign m0f.penable = q_sel[0];
  assign m1f.paddr = q_addr[1];
  assign m1f.pdata = q_data[1];
  assign m1f.pwrite = q_wr[1];
  assign m1f.pstb = q_stb[1];
  assign m1f.psel = q_sel[1] & use_fx;
  assign m1f.penable = q_sel[1];
  assign sr.prdata = s_rdata;
  assign sr.pready = s_rdy & ~use_fx;
  assign sr.perr = s_err;
  assign sf.prdata = s_rdata;
  assign sf.pready = s_rdy & use_fx;
  assign sf.perr = s_err;

  logic [1:0]  o_grant;
  logic        o_busy, o_psel, o_pen, o_pwr;
  logic [31:0] o_paddr, o_pdata;
  logic [3:0]  o_pstb;
  logic [1:0]  o_rdy, o_err;
  logic [31:0] o_rdata0, o_rdata1;

  assign o_grant = use_fx ? g_f : g_r;
  assign o_busy = use_fx ? b_f : b_r;
  assign o_psel = use_fx ? sf.psel : sr.psel;
  assign o_pen = use_fx ? sf.penable : sr.penable;
  assign o_pwr = use_fx ? sf.pwrite : sr.pwrite;
  assign o_paddr = use_fx ? sf.paddr : sr.paddr;
  assign o_pdata = use_fx ? sf.pdata : sr.pdata;
  assign o_pstb = use_fx ? sf.pstb : sr.pstb;
  assign o_rdy = use_fx ? {m1f.pready, m0f.pready} : {m1r.pready, m0r.pready};
  assign o_err = use_fx ? {m1f.perr, m0f.perr} : {m1r.perr, m0r.perr};
  assign o_rdata0 = use_fx ? m0f.prdata : m0r.prdata;
  assign o_rdata1 = use_fx ? m1f.prdata : m1r.prdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      q_sel[n] = 1'b0;
      q_addr[n] = '0;
      q_data[n] = '0;
      q_wr[n] = 1'b0;
      q_stb[n] = '0;
    end
    s_rdy = 1'b0;
    s_err = 1'b0;
    s_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    use_fx = 1'b0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({o_grant, o_busy, o_psel, o_pen, o_rdy} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b required 0", {o_grant, o_busy, o_psel, o_pen, o_rdy});
    end
    n_chk++;
    if (o_paddr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_paddr: got %h required 0", o_paddr);
    end
    do_reset();
    q_sel[0] = 1'b1;
    q_addr[0] = 32'h0000_4444;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    n_chk++;
    if (o_pen !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_access: penable got %b required 1", o_pen);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({o_psel, o_pen, o_grant, o_busy} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid_access: got %b required 0", {o_psel, o_pen, o_grant, o_busy});
    end
    q_sel[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    use_fx = 1'b0;
    do_reset();
    s_rdy = 1'b1;
    q_sel[0] = 1'b1;
    q_addr[0] = 32'h0000_1000;
    q_data[0] = 32'hDEAD_BEEF;
    q_wr[0] = 1'b1;
    q_stb[0] = 4'hF;
    @(posedge clk);
    #2;
    n_chk++;
    if ({o_psel, o_pen, o_grant, o_rdy} !== 6'b10_01_00) begin
      n_fail++;
      $display("FAIL wr_setup: got %b required 100100", {o_psel, o_pen, o_grant, o_rdy});
    end
    @(posedge clk);
    #2;
    n_chk++;
    if ({o_psel, o_pen, o_rdy, o_err} !== 6'b11_01_00) begin
      n_fail++;
      $display("FAIL wr_access: got %b required 110100", {o_psel, o_pen, o_rdy, o_err});
    end
    n_chk++;
    if ({o_paddr, o_pdata, o_pwr, o_pstb} !== {32'h1000, 32'hDEADBEEF, 1'b1, 4'hF}) begin
      n_fail++;
      $display("FAIL wr_payload: got %h %h %b %h", o_paddr, o_pdata, o_pwr, o_pstb);
    end
    q_sel[0] = 1'b0;
    @(posedge clk);
    #2;
    n_chk++;
    if ({o_psel, o_pen, o_grant, o_busy, o_rdy} !== 7'd0) begin
      n_fail++;
      $display("FAIL wr_idle: got %b required 0", {o_psel, o_pen, o_grant, o_busy, o_rdy});
    end
  endtask

  task automatic test_rr_fair();
    int got;
    int idx;
    use_fx = 1'b0;
    do_reset();
    s_rdy = 1'b1;
    got = 0;
    q_addr[0] = 32'h100;
    q_addr[1] = 32'h200;
    q_sel[0] = 1'b1;
    q_sel[1] = 1'b1;
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(posedge clk);
      #2;
      if (o_rdy != 2'b00) begin
        idx = o_rdy[1] ? 1 : 0;
        n_chk++;
        if (o_rdy === 2'b11 || idx != got % 2) begin
          n_fail++;
          $display("FAIL rr_order: transfer %0d pready %b required owner %0d", got, o_rdy, got % 2);
        end
        n_chk++;
        if (o_paddr !== q_addr[idx]) begin
          n_fail++;
          $display("FAIL rr_addr: got %h required %h", o_paddr, q_addr[idx]);
        end
        q_addr[idx] = q_addr[idx] + 32'd4;
        got++;
      end
    end
    n_chk++;
    if (got < 6) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d transfers required 6", got);
    end
    idle_inputs();
    @(posedge clk);
    #1;
  endtask

  task automatic test_fixed_prio();
    int got;
    int m1_got;
    use_fx = 1'b1;
    do_reset();
    s_rdy = 1'b1;
    got = 0;
    m1_got = 0;
    q_addr[0] = 32'hA0;
    q_addr[1] = 32'hB0;
    q_sel[0] = 1'b1;
    q_sel[1] = 1'b1;
    for (int c = 0; c < 60 && m1_got == 0; c++) begin
      @(posedge clk);
      #2;
      if (o_rdy != 2'b00) begin
        n_chk++;
        if (got < 4 && o_rdy !== 2'b01) begin
          n_fail++;
          $display("FAIL fx_m0_wins: transfer %0d pready %b required 01", got, o_rdy);
        end else if (got >= 4 && o_rdy !== 2'b10) begin
          n_fail++;
          $display("FAIL fx_m1_after_drop: pready %b required 10", o_rdy);
        end
        if (o_rdy[1])
          m1_got++;
        got++;
        if (got == 4)
          q_sel[0] = 1'b0;
      end
    end
    n_chk++;
    if (m1_got != 1 || got != 5) begin
      n_fail++;
      $display("FAIL fx_timeout: got %0d/%0d transfers required 5/1", got, m1_got);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    use_fx = 1'b0;
  endtask

  task automatic test_wait_err();
    int acc;
    bit seen;
    use_fx = 1'b0;
    do_reset();
    acc = 0;
    seen = 0;
    q_sel[1] = 1'b1;
    q_addr[1] = 32'h2004;
    q_wr[1] = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (o_psel && o_pen) begin
        acc++;
        s_rdy = (acc == 6);
        s_err = (acc == 6);
        s_rdata = (acc == 6) ? 32'h55 : 32'h0;
      end else begin
        s_rdy = 1'b0;
        s_err = 1'b0;
      end
      #1;
      if (o_rdy[1]) begin
        seen = 1;
        n_chk++;
        if (acc != 6) begin
          n_fail++;
          $display("FAIL we_access_len: got %0d penable cycles required 6", acc);
        end
        n_chk++;
        if ({o_rdy, o_err} !== 4'b1010 || o_rdata1 !== 32'h55) begin
          n_fail++;
          $display("FAIL we_resp: rdy %b err %b rdata %h required 10 10 55", o_rdy, o_err, o_rdata1);
        end
        n_chk++;
        if (o_paddr !== 32'h2004 || o_pwr !== 1'b0) begin
          n_fail++;
          $display("FAIL we_req: addr %h wr %b required 2004 0", o_paddr, o_pwr);
        end
        q_sel[1] = 1'b0;
      end else if (o_rdy[0] || o_err != 2'b00) begin
        n_chk++;
        n_fail++;
        $display("FAIL we_stray: rdy %b err %b required 00", o_rdy, o_err);
      end
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL we_timeout: no m1_pready");
    end
    @(posedge clk);
    #2;
    n_chk++;
    if ({o_pen, o_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL we_idle: got %b required 00", {o_pen, o_busy});
    end
    idle_inputs();
  endtask

  task automatic test_addr_hold();
    int acc;
    bit seen;
    use_fx = 1'b0;
    do_reset();
    acc = 0;
    seen = 0;
    q_sel[0] = 1'b1;
    q_addr[0] = 32'h3000;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (o_psel && o_pen) begin
        acc++;
        q_addr[0] = 32'hBAD0_0000 + acc;
        s_rdy = (acc == 3);
      end
      #1;
      if (o_busy) begin
        n_chk++;
        if (o_paddr !== 32'h3000) begin
          n_fail++;
          $display("FAIL hold_addr: got %h required 3000", o_paddr);
        end
      end
      if (o_rdy[0]) begin
        seen = 1;
        q_sel[0] = 1'b0;
      end
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL hold_timeout: no m0_pready");
    end
    idle_inputs();
    @(posedge clk);
    #1;
  endtask

  task automatic test_random(input logic fx, input int ncyc);
    int own;
    int age;
    int last;
    int wleft;
    logic [31:0] ca, cd;
    logic cw;
    logic [3:0] cs;
    logic [1:0] e_grant, e_rdy, done;
    logic e_pen;
    use_fx = fx;
    do_reset();
    own = -1;
    age = 0;
    last = 1;
    wleft = 0;
    done = 2'b00;
    ca = '0;
    cd = '0;
    cw = 1'b0;
    cs = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      if (own < 0) begin
        if (q_sel[0] && q_sel[1])
          own = fx ? 0 : 1 - last;
        else if (q_sel[0])
          own = 0;
        else if (q_sel[1])
          own = 1;
        if (own >= 0) begin
          age = 0;
          ca = q_addr[own];
          cd = q_data[own];
          cw = q_wr[own];
          cs = q_stb[own];
        end
      end else if (age >= 1 && s_rdy) begin
        last = own;
        own = -1;
      end else begin
        age++;
      end
      for (int n = 0; n < 2; n++) begin
        if (done[n] || !q_sel[n]) begin
          q_sel[n] = ($urandom_range(0, 2) == 0);
          q_addr[n] = $urandom;
          q_data[n] = $urandom;
          q_wr[n] = $urandom_range(0, 1);
          q_stb[n] = $urandom_range(0, 15);
        end
      end
      if (o_psel && !o_pen) begin
        wleft = $urandom_range(0, 3);
        s_rdy = $urandom_range(0, 1);
      end else if (o_psel && o_pen) begin
        s_rdy = (wleft == 0);
        if (wleft > 0)
          wleft--;
      end else begin
        s_rdy = $urandom_range(0, 1);
      end
      s_err = $urandom_range(0, 1);
      s_rdata = $urandom;
      #1;
      e_grant = (own < 0) ? 2'b00 : (own == 0 ? 2'b01 : 2'b10);
      e_pen = (own >= 0) && (age >= 1);
      e_rdy[0] = e_pen && own == 0 && s_rdy;
      e_rdy[1] = e_pen && own == 1 && s_rdy;
      n_chk++;
      if ({o_grant, o_busy, o_psel, o_pen} !== {e_grant, own >= 0, own >= 0, e_pen}) begin
        n_fail++;
        $display("FAIL rnd_phase: cyc %0d got %b required %b", c, {o_grant, o_busy, o_psel, o_pen}, {e_grant, own >= 0, own >= 0, e_pen});
      end
      n_chk++;
      if (o_rdy !== e_rdy || o_err !== (e_rdy & {s_err, s_err})) begin
        n_fail++;
        $display("FAIL rnd_resp: cyc %0d rdy %b err %b required %b %b", c, o_rdy, o_err, e_rdy, e_rdy & {s_err, s_err});
      end
      if (own >= 0) begin
        n_chk++;
        if ({o_paddr, o_pdata, o_pwr, o_pstb} !== {ca, cd, cw, cs}) begin
          n_fail++;
          $display("FAIL rnd_payload: cyc %0d got %h %h %b %h required %h %h %b %h", c, o_paddr, o_pdata, o_pwr, o_pstb, ca, cd, cw, cs);
        end
      end
      if (e_rdy != 2'b00) begin
        n_chk++;
        if ((e_rdy[0] ? o_rdata0 : o_rdata1) !== s_rdata) begin
          n_fail++;
          $display("FAIL rnd_rdata: cyc %0d required %h", c, s_rdata);
        end
      end
      done = e_rdy;
    end
    idle_inputs();
    @(posedge clk);
    #1;
    use_fx = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    use_fx = 1'b0;
    rst_n = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_rr_fair();
    test_fixed_prio();
    test_wait_err();
    test_addr_hold();
    test_random(1'b0, 500);
    test_random(1'b1, 500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
